mux_tree_pipelined: RTL and testbench
=====================================

Name: mux_tree_pipelined

Overview:
Parametrised N-to-1 selector with WIDTH-bit channels, built as a binary tree of 2:1 selection layers with a pipeline register after every layer. It carries a valid flag, the enable and the selected channel index alongside the data. An optional scan mode uses an internal wrapping pointer as the select, so the block can sequentially sample all channels. It sits in front of shared datapath resources that time-multiplex N sources.

Parameters:
WIDTH, 8, data bits per channel (>=1)
SEL_W, 3, select width; channel count N = 2**SEL_W (>=1); also the pipeline depth

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
data  input  N*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
sel  input  SEL_W  external channel select, used when scan=0
in_valid  input  1  beat valid at stage 0
en_n  input  1  active-low enable, travels with the beat
scan  input  1  1 = select comes from the internal scan_ptr
stall  input  1  1 = freeze all pipeline registers and scan_ptr
out  output  WIDTH  selected data, registered
out_n  output  WIDTH  bitwise ~out
out_valid  output  1  out/out_sel hold a valid beat
out_sel  output  SEL_W  effective select of the beat on out
scan_ptr  output  SEL_W  current scan pointer

Behaviour:
- Reset (async, immediate): all stage data/valid/en/select registers clear to 0; out=0, out_n=all ones, out_valid=0, out_sel=0, scan_ptr=0. Reset mid-flight discards all beats in flight.
- Effective select: esel = scan ? scan_ptr : sel. Sampled together with data, in_valid and en_n on an accepted edge.
- Tree: layer k (k=0..SEL_W-1) pairs its inputs (2i, 2i+1) and chooses 2i+1 when esel bit k = 1. LSB is resolved first. Layer k output is registered as stage k+1. esel bits k+1..SEL_W-1 and the full esel (for out_sel) are carried in the same stage registers.
- Latency: exactly SEL_W clock edges, with stall=0, from input sample to out/out_valid. The final layer register drives out directly.
- Valid/enable handling:
  - A stage with valid=0 loads zero data.
  - At the final stage, out = (valid & ~en) ? tree_result : 0.
  - out_valid follows the valid bit, independent of en_n.
  - A disabled valid beat therefore gives out_valid=1, out=0, out_n=all ones.
- Throughput: one beat per clock. No bubbles are inserted.
- stall=1: every register, including scan_ptr, holds its value; inputs are ignored that cycle. stall has priority over in_valid.
- scan_ptr:
  - Increments by 1 on each edge with scan & in_valid & ~stall. Wraps from N-1 to 0.
  - Holds when scan=0, when in_valid=0, or during stall.
  - The beat that uses scan_ptr=p is the same beat that advances it to p+1.
- SEL_W=1: single layer, latency 1, scan_ptr toggles 0/1.
- All arithmetic is unsigned, modulo 2**SEL_W.

Test Plan:
- Reset: assert rst mid-stream with 3 beats in flight -> immediately out=0, out_n=0xFF, out_valid=0, scan_ptr=0. After release, the first new beat appears 3 cycles later.
- Directed select (WIDTH=8, SEL_W=3): channel c = 0x10+c. Drive sel=0..7 on consecutive cycles with in_valid=1 -> out=0x10..0x17 with out_sel=0..7, starting exactly 3 cycles after the first sample, back-to-back.
- Enable: sel=5, en_n=1, in_valid=1 -> after 3 cycles out_valid=1, out=0x00, out_n=0xFF. Next beat with en_n=0 -> out=0x15.
- Stall: with a beat at stage 2, hold stall=1 for 4 cycles -> out, out_valid and scan_ptr unchanged. The beat emerges 1 cycle after stall drops, for a total latency of 3+4.
- Scan wrap: scan=1, in_valid=1 for 10 cycles -> out_sel sequence 0..7,0,1 and scan_ptr=2 at the end. Deassert in_valid for 2 cycles -> scan_ptr holds at 2.
- Parameter sweep: SEL_W=1, WIDTH=1 and SEL_W=4, WIDTH=16 with random data/sel versus a reference model delayed SEL_W cycles -> zero mismatches over 10k beats.

Source files
------------

// File: rtl/mux_tree_pipelined.sv
// mux_tree_pipelined: N-to-1 channel selector built as a binary tree of 2:1
// layers, one pipeline register per layer. A valid flag, the active-low
// enable and the effective select travel with each beat. In scan mode the
// select comes from an internal wrapping pointer so all channels can be
// visited in turn.
module mux_tree_pipelined #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**SEL_W)*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  input  logic                        en_n,
  input  logic                        scan,
  input  logic                        stall,
  output logic [WIDTH-1:0]            out,
  output logic [WIDTH-1:0]            out_n,
  output logic                        out_valid,
  output logic [SEL_W-1:0]            out_sel,
  output logic [SEL_W-1:0]            scan_ptr
);

  localparam int N    = 2 ** SEL_W;
  localparam int LAST = SEL_W - 1;

  logic [SEL_W-1:0] r_scan_ptr;
  logic [SEL_W-1:0] w_esel;

  // The beat that uses scan pointer p is the one that advances it to p+1.
  assign w_esel = scan ? r_scan_ptr : sel;

  // Scan pointer: step once per accepted scan beat, wrapping modulo N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_ptr <= '0;
    end else if (!stall && scan && in_valid) begin
      r_scan_ptr <= r_scan_ptr + SEL_W'(1);
    end
  end

  assign scan_ptr = r_scan_ptr;

  // Layer gi halves the channel count using esel bit gi (LSB resolved first).
  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_layer
    localparam int NI = N >> gi;
    localparam int NO = NI / 2;

    logic [NI*WIDTH-1:0] w_in;
    logic                w_in_valid;
    logic                w_in_en_n;
    logic [SEL_W-1:0]    w_in_sel;
    logic [NO*WIDTH-1:0] w_pick;

    logic [NO*WIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_en_n;
    logic [SEL_W-1:0]    r_sel;

    if (gi == 0) begin : g_src
      assign w_in       = data;
      assign w_in_valid = in_valid;
      assign w_in_en_n  = en_n;
      assign w_in_sel   = w_esel;
    end else begin : g_src
      assign w_in       = g_layer[gi-1].r_data;
      assign w_in_valid = g_layer[gi-1].r_valid;
      assign w_in_en_n  = g_layer[gi-1].r_en_n;
      assign w_in_sel   = g_layer[gi-1].r_sel;
    end

    for (genvar gj = 0; gj < NO; gj++) begin : g_pair
      assign w_pick[gj*WIDTH +: WIDTH] = w_in_sel[gi]
                                       ? w_in[(2*gj+1)*WIDTH +: WIDTH]
                                       : w_in[(2*gj)*WIDTH +: WIDTH];
    end

    // Stage register: holds under stall; empty beats carry zero data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
        r_en_n  <= 1'b0;
        r_sel   <= '0;
      end else if (!stall) begin
        r_data  <= w_in_valid ? w_pick : '0;
        r_valid <= w_in_valid;
        r_en_n  <= w_in_en_n;
        r_sel   <= w_in_sel;
      end
    end
  end

  // A disabled valid beat still reports out_valid but presents zero data.
  assign out       = (g_layer[LAST].r_valid && !g_layer[LAST].r_en_n)
                   ? g_layer[LAST].r_data : '0;
  assign out_n     = ~out;
  assign out_valid = g_layer[LAST].r_valid;
  assign out_sel   = g_layer[LAST].r_sel;

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Bench for mux_tree_pipelined: directed scenarios on an 8x8 instance plus
// random sweeps of a 2x1 and a 16x16 instance, all checked against a queue
// of expected beats built from the stimulus.
module tb_mux_tree_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance: WIDTH=8, SEL_W=3 ----------------
  logic [63:0] data;
  logic [2:0]  sel;
  logic        in_valid, en_n, scan, stall;
  logic [7:0]  out, out_n;
  logic        out_valid;
  logic [2:0]  out_sel, scan_ptr;

  mux_tree_pipelined #(.WIDTH(8), .SEL_W(3)) u_dut (
    .clk(clk), .rst(rst), .data(data), .sel(sel), .in_valid(in_valid),
    .en_n(en_n), .scan(scan), .stall(stall), .out(out), .out_n(out_n),
    .out_valid(out_valid), .out_sel(out_sel), .scan_ptr(scan_ptr)
  );

  // ---------------- small instance: WIDTH=1, SEL_W=1 ----------------
  logic [1:0] s_data;
  logic [0:0] s_sel, s_out, s_out_n, s_out_sel, s_ptr;
  logic       s_valid, s_en_n, s_scan, s_stall, s_out_valid;

  mux_tree_pipelined #(.WIDTH(1), .SEL_W(1)) u_small (
    .clk(clk), .rst(rst), .data(s_data), .sel(s_sel), .in_valid(s_valid),
    .en_n(s_en_n), .scan(s_scan), .stall(s_stall), .out(s_out), .out_n(s_out_n),
    .out_valid(s_out_valid), .out_sel(s_out_sel), .scan_ptr(s_ptr)
  );

  // ---------------- large instance: WIDTH=16, SEL_W=4 ----------------
  logic [255:0] l_data;
  logic [3:0]   l_sel, l_out_sel, l_ptr;
  logic [15:0]  l_out, l_out_n;
  logic         l_valid, l_en_n, l_scan, l_stall, l_out_valid;

  mux_tree_pipelined #(.WIDTH(16), .SEL_W(4)) u_large (
    .clk(clk), .rst(rst), .data(l_data), .sel(l_sel), .in_valid(l_valid),
    .en_n(l_en_n), .scan(l_scan), .stall(l_stall), .out(l_out), .out_n(l_out_n),
    .out_valid(l_out_valid), .out_sel(l_out_sel), .scan_ptr(l_ptr)
  );

  typedef struct packed { logic v; logic [7:0] d;  logic [2:0] s; } m_t;
  typedef struct packed { logic v; logic [0:0] d;  logic [0:0] s; } s_t;
  typedef struct packed { logic v; logic [15:0] d; logic [3:0] s; } l_t;

  m_t         q[$];
  m_t         cur;
  logic [2:0] m_ptr;

  int total = 0;
  int bad   = 0;

  task automatic clear_model;
    q.delete();
    cur   = '0;
    m_ptr = 3'd0;
  endtask

  // Drive one beat into the main instance and advance the expected-beat queue.
  task automatic step(input logic v, input logic e, input logic sc,
                      input logic st, input logic [2:0] sl);
    logic [2:0] es;
    in_valid = v; en_n = e; scan = sc; stall = st; sel = sl;
    es = sc ? m_ptr : sl;
    @(posedge clk);
    if (!st) begin
      q.push_back(m_t'{v, (v && !e) ? (8'h10 + {5'd0, es}) : 8'h00, es});
      if (sc && v) m_ptr = m_ptr + 3'd1;
      if (q.size() == 3) cur = q.pop_front();
    end
    #1;
    $display("beat t=%0t v=%0b en_n=%0b scan=%0b stall=%0b sel=%0d -> out=%h vld=%0b osel=%0d ptr=%0d",
             $time, v, e, sc, st, sl, out, out_valid, out_sel, scan_ptr);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out !== 8'h00)    begin bad++; $display("FAIL rst_out got=%h exp=00", out); end
    total++; if (out_n !== 8'hFF)  begin bad++; $display("FAIL rst_out_n got=%h exp=ff", out_n); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (scan_ptr !== 3'd0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", scan_ptr); end
    @(negedge clk); rst = 1'b0; clear_model();
    // three scan beats in flight, then an asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    total++; if (out_valid !== cur.v) begin bad++; $display("FAIL pre_rst_valid got=%b exp=%b", out_valid, cur.v); end
    #1 rst = 1'b1;
    #1;
    total++; if (out !== 8'h00)    begin bad++; $display("FAIL async_out got=%h exp=00", out); end
    total++; if (out_n !== 8'hFF)  begin bad++; $display("FAIL async_out_n got=%h exp=ff", out_n); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", out_valid); end
    total++; if (scan_ptr !== 3'd0) begin bad++; $display("FAIL async_ptr got=%0d exp=0", scan_ptr); end
    in_valid = 1'b0; scan = 1'b0;
    @(negedge clk); rst = 1'b0; clear_model();
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 1'b0, 1'b0, 1'b0, 3'd6);
      total++; if (out_valid !== (i == 2)) begin bad++; $display("FAIL post_rst_valid[%0d] got=%b exp=%b", i, out_valid, (i == 2)); end
      total++; if (out !== cur.d) begin bad++; $display("FAIL post_rst_out[%0d] got=%h exp=%h", i, out, cur.d); end
    end
  endtask

  task automatic test_select;
    for (int c = 0; c < 11; c++) begin
      step(c < 8, 1'b0, 1'b0, 1'b0, 3'(c));
      total++; if (out_valid !== cur.v) begin bad++; $display("FAIL sel_valid[%0d] got=%b exp=%b", c, out_valid, cur.v); end
      total++; if (out !== cur.d) begin bad++; $display("FAIL sel_out[%0d] got=%h exp=%h", c, out, cur.d); end
      if (cur.v) begin
        total++; if (out_sel !== cur.s) begin bad++; $display("FAIL sel_osel[%0d] got=%0d exp=%0d", c, out_sel, cur.s); end
      end
    end
  endtask

  task automatic test_enable;
    for (int c = 0; c < 5; c++) begin
      step(c < 2, c == 0, 1'b0, 1'b0, 3'd5);
      total++; if (out_valid !== cur.v) begin bad++; $display("FAIL en_valid[%0d] got=%b exp=%b", c, out_valid, cur.v); end
      total++; if (out !== cur.d) begin bad++; $display("FAIL en_out[%0d] got=%h exp=%h", c, out, cur.d); end
      total++; if (out_n !== ~cur.d) begin bad++; $display("FAIL en_out_n[%0d] got=%h exp=%h", c, out_n, ~cur.d); end
    end
  endtask

  task automatic test_stall;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'd7);
      total++; if (out_valid !== cur.v) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=%b", c, out_valid, cur.v); end
      total++; if (out !== cur.d) begin bad++; $display("FAIL stall_out[%0d] got=%h exp=%h", c, out, cur.d); end
      total++; if (scan_ptr !== m_ptr) begin bad++; $display("FAIL stall_ptr[%0d] got=%0d exp=%0d", c, scan_ptr, m_ptr); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_emerge_valid got=%b exp=1", out_valid); end
    total++; if (out !== 8'h12) begin bad++; $display("FAIL stall_emerge_out got=%h exp=12", out); end
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_scan_wrap;
    for (int c = 0; c < 15; c++) begin
      step(c < 10, 1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
      total++; if (out_valid !== cur.v) begin bad++; $display("FAIL scan_valid[%0d] got=%b exp=%b", c, out_valid, cur.v); end
      total++; if (scan_ptr !== m_ptr) begin bad++; $display("FAIL scan_ptr[%0d] got=%0d exp=%0d", c, scan_ptr, m_ptr); end
      if (cur.v) begin
        total++; if (out_sel !== cur.s) begin bad++; $display("FAIL scan_osel[%0d] got=%0d exp=%0d", c, out_sel, cur.s); end
        total++; if (out !== cur.d) begin bad++; $display("FAIL scan_out[%0d] got=%h exp=%h", c, out, cur.d); end
      end
      if (c == 11) begin
        total++; if (scan_ptr !== 3'd2) begin bad++; $display("FAIL scan_ptr_hold got=%0d exp=2", scan_ptr); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
           ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      total++; if (out_valid !== cur.v) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", c, out_valid, cur.v); end
      total++; if (out !== cur.d) begin bad++; $display("FAIL b2b_out[%0d] got=%h exp=%h", c, out, cur.d); end
      total++; if (out_n !== ~cur.d) begin bad++; $display("FAIL b2b_out_n[%0d] got=%h exp=%h", c, out_n, ~cur.d); end
      total++; if (scan_ptr !== m_ptr) begin bad++; $display("FAIL b2b_ptr[%0d] got=%0d exp=%0d", c, scan_ptr, m_ptr); end
      if (cur.v) begin
        total++; if (out_sel !== cur.s) begin bad++; $display("FAIL b2b_osel[%0d] got=%0d exp=%0d", c, out_sel, cur.s); end
      end
    end
  endtask

  task automatic test_sweep_small;
    s_t         sq[$];
    s_t         scur;
    logic [0:0] sp;
    logic [0:0] es;
    scur = '0; sp = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      s_data = 2'($urandom); s_sel = 1'($urandom); s_valid = 1'($urandom);
      s_en_n = ($urandom_range(0, 3) == 0); s_scan = 1'($urandom);
      es = s_scan ? sp : s_sel;
      @(posedge clk);
      sq.push_back(s_t'{s_valid, (s_valid && !s_en_n) ? s_data[es] : 1'b0, es});
      if (s_scan && s_valid) sp = sp + 1'b1;
      if (sq.size() == 1) scur = sq.pop_front();
      #1;
      total++; if (s_out_valid !== scur.v) begin bad++; $display("FAIL small_valid[%0d] got=%b exp=%b", c, s_out_valid, scur.v); end
      total++; if (s_out !== scur.d) begin bad++; $display("FAIL small_out[%0d] got=%b exp=%b", c, s_out, scur.d); end
      total++; if (s_out_n !== ~scur.d) begin bad++; $display("FAIL small_out_n[%0d] got=%b exp=%b", c, s_out_n, ~scur.d); end
      total++; if (s_ptr !== sp) begin bad++; $display("FAIL small_ptr[%0d] got=%b exp=%b", c, s_ptr, sp); end
      if (scur.v) begin
        total++; if (s_out_sel !== scur.s) begin bad++; $display("FAIL small_osel[%0d] got=%b exp=%b", c, s_out_sel, scur.s); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_sweep_large;
    l_t         lq[$];
    l_t         lcur;
    logic [3:0] lp;
    logic [3:0] es;
    lcur = '0; lp = 4'd0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 8; k++) l_data[k*32 +: 32] = $urandom;
      l_sel = 4'($urandom); l_valid = 1'($urandom);
      l_en_n = ($urandom_range(0, 3) == 0); l_scan = 1'($urandom);
      es = l_scan ? lp : l_sel;
      @(posedge clk);
      lq.push_back(l_t'{l_valid, (l_valid && !l_en_n) ? l_data[es*16 +: 16] : 16'h0, es});
      if (l_scan && l_valid) lp = lp + 4'd1;
      if (lq.size() == 4) lcur = lq.pop_front();
      #1;
      total++; if (l_out_valid !== lcur.v) begin bad++; $display("FAIL large_valid[%0d] got=%b exp=%b", c, l_out_valid, lcur.v); end
      total++; if (l_out !== lcur.d) begin bad++; $display("FAIL large_out[%0d] got=%h exp=%h", c, l_out, lcur.d); end
      total++; if (l_out_n !== ~lcur.d) begin bad++; $display("FAIL large_out_n[%0d] got=%h exp=%h", c, l_out_n, ~lcur.d); end
      total++; if (l_ptr !== lp) begin bad++; $display("FAIL large_ptr[%0d] got=%0d exp=%0d", c, l_ptr, lp); end
      if (lcur.v) begin
        total++; if (l_out_sel !== lcur.s) begin bad++; $display("FAIL large_osel[%0d] got=%0d exp=%0d", c, l_out_sel, lcur.s); end
      end
    end
    l_valid = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 8; c++) data[c*8 +: 8] = 8'h10 + 8'(c);
    sel = 3'd0; in_valid = 1'b0; en_n = 1'b0; scan = 1'b0; stall = 1'b0;
    s_data = 2'd0; s_sel = 1'b0; s_valid = 1'b0; s_en_n = 1'b0; s_scan = 1'b0; s_stall = 1'b0;
    l_data = '0; l_sel = 4'd0; l_valid = 1'b0; l_en_n = 1'b0; l_scan = 1'b0; l_stall = 1'b0;
    clear_model();
    test_reset();
    test_select();
    test_enable();
    test_stall();
    test_scan_wrap();
    test_back_to_back();
    test_sweep_small();
    test_sweep_large();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
